// File: rtl/signal_phase_timer.sv
// +--------------------------------------------------------------------------+
// | Module   : signal_phase_timer                                            |
// | Purpose  : Pacing stage for the traffic signal lamp FSM. Prescales CLK   |
// |            into step ticks, holds each lamp phase for a dwell chosen     |
// |            from the lamp state code, and pulses the active-low advance   |
// |            enable for one cycle when the dwell expires. Also handles     |
// |            pedestrian-request shortening and an external hold.           |
// | Option   : SIGLAMP_NIGHT_FLASH_EN adds the NIGHT input / FLASH output.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module signal_phase_timer #(
  parameter int PRESCALE    = 1000,
  parameter int LONG_DWELL  = 30,
  parameter int SHORT_DWELL = 5,
  parameter int PED_DWELL   = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] STATE,
  input  logic       PED_REQ,
  input  logic       HOLD,
  output logic       ADV_N,
  output logic       TICK,
  output logic [7:0] REMAIN,
`ifdef SIGLAMP_NIGHT_FLASH_EN
  input  logic       NIGHT,
  output logic       FLASH,
`endif
  output logic       PED_ACK
);

  localparam int            CW       = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [7:0]    LONG_D   = 8'(LONG_DWELL);
  localparam logic [7:0]    SHORT_D  = 8'(SHORT_DWELL);
  localparam logic [7:0]    PED_D    = 8'(PED_DWELL);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_STEP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [7:0]    remain_q, remain_d;
  logic          adv_n_q, adv_n_d;
  logic          ped_ack_q, ped_ack_d;
  logic          ped_pend_q, ped_pend_d;
  logic          ped_meta_q, ped_meta_d;
  logic          ped_sync_q, ped_sync_d;
  logic          ped_prev_q, ped_prev_d;

  logic          tick_live;
  logic          ped_rise;
  logic          is_short;
  logic [7:0]    dwell;
  logic [7:0]    ped_clamped;

  // Only the low two lamp state bits select the dwell class.
  logic unused_state_hi;
  assign unused_state_hi = ^STATE[4:2];

  // A pending tick is frozen (not lost) while HOLD is high.
  assign tick_live   = tick_q & ~HOLD;
  assign ped_rise    = ped_sync_q & ~ped_prev_q;
  assign is_short    = (STATE[1:0] == 2'b11);
  assign dwell       = is_short ? SHORT_D : LONG_D;
  assign ped_clamped = (remain_q < PED_D) ? remain_q : PED_D;

`ifdef SIGLAMP_NIGHT_FLASH_EN
  logic flash_q, flash_d;
`endif

  // Free-running prescaler and pedestrian synchronizer next-state.
  always_comb begin
    cnt_d      = cnt_q;
    tick_d     = tick_q;
    ped_meta_d = PED_REQ;
    ped_sync_d = ped_meta_q;
    ped_prev_d = ped_sync_q;
    if (!HOLD) begin
      tick_d = (cnt_q == CNT_LAST);
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Phase FSM next-state, dwell countdown and pedestrian clamp.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    ped_ack_d  = 1'b0;
    ped_pend_d = ped_pend_q | ped_rise;
    adv_n_d    = 1'b1;
`ifdef SIGLAMP_NIGHT_FLASH_EN
    flash_d    = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        remain_d = dwell;
        state_d  = ST_COUNT;
      end
      ST_COUNT: begin
        if (!HOLD) begin
          // The clamp takes priority; a coincident tick is dropped.
          if (ped_pend_q && !is_short) begin
            remain_d   = ped_clamped;
            ped_pend_d = 1'b0;
            ped_ack_d  = 1'b1;
          end else if (tick_q) begin
            if (remain_q <= 8'd1) begin
              remain_d = 8'd0;
              state_d  = ST_STEP;
            end else begin
              remain_d = remain_q - 8'd1;
            end
          end
        end
      end
      ST_STEP: begin
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
`ifdef SIGLAMP_NIGHT_FLASH_EN
    if (NIGHT) begin
      state_d    = ST_LOAD;
      remain_d   = 8'd0;
      ped_pend_d = 1'b0;
      ped_ack_d  = 1'b0;
      flash_d    = flash_q ^ tick_live;
    end
`endif
    // Registered so the lamp sees a clean, glitch-free low pulse.
    adv_n_d = (state_d != ST_STEP);
  end

  // State registers; reset aborts any phase and any advance pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      remain_q   <= 8'd0;
      adv_n_q    <= 1'b1;
      ped_ack_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      ped_meta_q <= 1'b0;
      ped_sync_q <= 1'b0;
      ped_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      remain_q   <= remain_d;
      adv_n_q    <= adv_n_d;
      ped_ack_q  <= ped_ack_d;
      ped_pend_q <= ped_pend_d;
      ped_meta_q <= ped_meta_d;
      ped_sync_q <= ped_sync_d;
      ped_prev_q <= ped_prev_d;
    end
  end

`ifdef SIGLAMP_NIGHT_FLASH_EN
  // Night flasher toggle register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flash_q <= 1'b0;
    end else begin
      flash_q <= flash_d;
    end
  end

  assign FLASH = flash_q;
`endif

  assign ADV_N   = adv_n_q;
  assign TICK    = tick_live;
  assign REMAIN  = remain_q;
  assign PED_ACK = ped_ack_q;

endmodule

`default_nettype wire
